if_fetch_stage: RTL and testbench
=================================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL provide: clk  input  1  rising-edge clock.
REQ-002 SHALL provide: reset  input  1  synchronous, active-high.
REQ-003 SHALL provide: PC_Write  input  1  1 = advance PC, 0 = hold (load-use stall from hazard unit).
REQ-004 SHALL provide: branch_taken  input  1  redirect request resolved downstream.
REQ-005 SHALL provide: branch_target  input  64  redirect address.
REQ-006 SHALL provide: imem_we  input  1  instruction-memory write enable.
REQ-007 SHALL provide: imem_waddr  input  4  word index for write.
REQ-008 SHALL provide: imem_wdata  input  32  word to write.
REQ-009 SHALL provide: PC_out  output  64  current fetch PC, feeds the IF/ID register.
REQ-010 SHALL provide: Instruction  output  32  fetched word, feeds the IF/ID register.
REQ-011 SHALL provide: IF_flush  output  1  clear request to the IF/ID register.
REQ-012 SHALL provide: halted  output  1  1 while in HALT state.
REQ-013 SHALL provide: fetch_count  output  32  sequential fetches retired.

Function
REQ-014 SHALL hold a 16 x 32-bit instruction memory, byte address PC[5:2] selects the word.
REQ-015 SHALL write imem_wdata to word imem_waddr on a rising edge with imem_we=1; reset does not clear memory.
REQ-016 SHALL read combinationally; a same-cycle write to the fetched word is visible only after the edge.
REQ-017 SHALL define a fetch as terminal when PC >= 64, PC[1:0] != 0, or the addressed word is 0x00000000.
REQ-018 SHALL drive Instruction = addressed word in RUN with a non-terminal fetch; otherwise 0x00000013 (NOP).
REQ-019 SHALL drive PC_out = PC register; IF_flush = branch_taken (combinational).
REQ-020 SHALL implement two states, RUN and HALT; halted = (state == HALT).
REQ-021 SHALL update the next PC by priority: branch_taken -> branch_target; else PC_Write=0 -> hold; else HALT -> hold; else terminal fetch -> hold; else PC+4 (64-bit wrap).
REQ-022 SHALL move RUN->HALT on an edge where branch_taken=0, PC_Write=1, and the fetch is terminal.
REQ-023 SHALL move HALT->RUN on an edge with branch_taken=1, loading branch_target.
REQ-024 SHALL remain in RUN when branch_taken=1 coincides with a terminal fetch; the redirect wins.
REQ-025 SHALL let branch_taken override PC_Write=0: a redirect is never stalled.
REQ-026 SHALL increment fetch_count only on edges where PC takes PC+4; saturate at 0xFFFFFFFF.

Reset
REQ-027 SHALL on reset=1 at an edge set PC=0, state=RUN, fetch_count=0; reset overrides branch_taken, PC_Write and any state, including mid-HALT.
REQ-028 SHALL produce after reset: PC_out=0, halted=0, fetch_count=0, Instruction=mem[0] or NOP per REQ-018, IF_flush=branch_taken.

Verification
REQ-029 SHALL cover sequential fetch: load words 0..3 = 0x00500093, 0x00A00113, 0x002081B3, 0; release reset, PC_Write=1 -> PC_out 0,4,8,12 on successive cycles; at PC=12 Instruction=0x00000013; halted=1 on the next cycle; fetch_count=3; PC holds at 12.
REQ-030 SHALL cover stall: PC_Write=0 for 2 cycles at PC=4 -> PC_out stays 4 and Instruction stays 0x00A00113; fetch_count unchanged; resumes at 8 once PC_Write=1.
REQ-031 SHALL cover redirect during stall: PC_Write=0, branch_taken=1, branch_target=0 in the same cycle -> IF_flush=1 that cycle; PC_out=0 next cycle; fetch_count unchanged.
REQ-032 SHALL cover HALT exit: in HALT apply branch_taken=1, target=4 -> halted=0 and PC_out=4 next cycle; branch_target=0x42 -> halted=1 one cycle after PC=0x42 with PC_Write=1 (misaligned and out-of-range).
REQ-033 SHALL cover reset mid-operation: assert reset while halted with fetch_count=3 -> next cycle PC_out=0, halted=0, fetch_count=0; memory contents retained.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: 16-word instruction memory, PC register with
// stall/redirect handling, a RUN/HALT controller that parks the stage on a
// terminal fetch, and a saturating count of sequential fetches.
module if_fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_Write,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        imem_we,
  input  logic [3:0]  imem_waddr,
  input  logic [31:0] imem_wdata,
  output logic [63:0] PC_out,
  output logic [31:0] Instruction,
  output logic        IF_flush,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [63:0] IMEM_SIZE = 64'd64;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic [31:0] mem [16];
  logic [31:0] word;
  logic        terminal;
  logic        advance;

  // Memory write port; deliberately not touched by reset so a program
  // survives a core reset.
  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
  end

  // Combinational read; a same-cycle write only shows up after the edge.
  always_comb begin
    word     = mem[pc[5:2]];
    terminal = (pc >= IMEM_SIZE) || (pc[1:0] != 2'b00) || (word == 32'h0);
  end

  // Next PC / next state by priority: redirect, stall, halt, terminal, +4.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    advance   = 1'b0;
    if (branch_taken) begin
      pc_nxt    = branch_target;
      state_nxt = RUN;
    end else if (!PC_Write) begin
      pc_nxt = pc;
    end else if (state == HALT) begin
      pc_nxt = pc;
    end else if (terminal) begin
      state_nxt = HALT;
    end else begin
      pc_nxt  = pc + 64'd4;
      advance = 1'b1;
    end
  end

  // PC, state and fetch counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= 64'h0;
      state       <= RUN;
      fetch_count <= 32'h0;
    end else begin
      pc    <= pc_nxt;
      state <= state_nxt;
      if (advance && (fetch_count != 32'hFFFF_FFFF))
        fetch_count <= fetch_count + 32'd1;
    end
  end

  // Output drive: a halted or terminal fetch presents a NOP downstream.
  always_comb begin
    PC_out      = pc;
    IF_flush    = branch_taken;
    halted      = (state == HALT);
    Instruction = ((state == RUN) && !terminal) ? word : NOP;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a behavioural model checked every cycle on the
// falling edge, plus directed literal checks after each rising edge.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PC_Write = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'h0;
  logic        imem_we = 1'b0;
  logic [3:0]  imem_waddr = 4'h0;
  logic [31:0] imem_wdata = 32'h0;
  logic [63:0] PC_out;
  logic [31:0] Instruction;
  logic        IF_flush;
  logic        halted;
  logic [31:0] fetch_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .PC_Write(PC_Write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .PC_out(PC_out), .Instruction(Instruction), .IF_flush(IF_flush),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Model state: architectural PC, halt flag, count, memory image.
  logic [63:0] m_pc;
  logic        m_halt;
  logic [31:0] m_cnt;
  logic [31:0] m_mem [16];

  function automatic bit m_term();
    if (m_pc >= 64) return 1'b1;
    if (m_pc % 4 != 0) return 1'b1;
    return m_mem[m_pc[5:2]] == 32'h0;
  endfunction

  always @(posedge clk) begin
    if (imem_we) m_mem[imem_waddr] <= imem_wdata;
    if (reset) begin
      m_pc <= 0; m_halt <= 0; m_cnt <= 0;
    end else if (branch_taken) begin
      m_pc <= branch_target; m_halt <= 0;
    end else if (PC_Write && !m_halt) begin
      if (m_term()) m_halt <= 1'b1;
      else begin
        m_pc <= m_pc + 4;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_pc", PC_out, m_pc);
      chk("m_halted", {63'h0, halted}, {63'h0, m_halt});
      chk("m_count", {32'h0, fetch_count}, {32'h0, m_cnt});
      chk("m_flush", {63'h0, IF_flush}, {63'h0, branch_taken});
      chk("m_instr", {32'h0, Instruction},
          {32'h0, (!m_halt && !m_term()) ? m_mem[m_pc[5:2]] : NOP});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic expect_state(input string tag, input logic [63:0] pc,
                              input logic h, input logic [31:0] cnt);
    chk({tag, "_pc"}, PC_out, pc);
    chk({tag, "_halted"}, {63'h0, halted}, {63'h0, h});
    chk({tag, "_count"}, {32'h0, fetch_count}, {32'h0, cnt});
  endtask

  logic [31:0] prog [16];

  initial begin
    for (int i = 0; i < 16; i++) prog[i] = 32'h0;
    prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113; prog[2] = 32'h0020_81B3;

    // Load the program while held in reset.
    for (int i = 0; i < 16; i++) begin
      imem_we = 1'b1; imem_waddr = 4'(i); imem_wdata = prog[i];
      step();
    end
    imem_we = 1'b0;
    step();
    chk_en = 1'b1;
    expect_state("rst", 64'd0, 1'b0, 32'd0);
    chk("rst_instr", {32'h0, Instruction}, 64'h0050_0093);
    chk("rst_flush", {63'h0, IF_flush}, 64'h0);

    // Sequential fetch down to the terminal zero word.
    reset = 1'b0; PC_Write = 1'b1; #1;
    chk("seq0_pc", PC_out, 64'd0);
    step(); expect_state("seq4", 64'd4, 1'b0, 32'd1);
    chk("seq4_instr", {32'h0, Instruction}, 64'h00A0_0113);
    step(); expect_state("seq8", 64'd8, 1'b0, 32'd2);
    chk("seq8_instr", {32'h0, Instruction}, 64'h0020_81B3);
    step(); expect_state("seq12", 64'd12, 1'b0, 32'd3);
    chk("seq12_instr", {32'h0, Instruction}, {32'h0, NOP});
    step(); expect_state("halt", 64'd12, 1'b1, 32'd3);
    step(); expect_state("halt_hold", 64'd12, 1'b1, 32'd3);

    // Reset while halted; memory must survive.
    reset = 1'b1; step(); reset = 1'b0;
    expect_state("rst_mid", 64'd0, 1'b0, 32'd0);
    chk("rst_mid_instr", {32'h0, Instruction}, 64'h0050_0093);

    // Load-use stall at PC=4.
    step(); expect_state("pre_stall", 64'd4, 1'b0, 32'd1);
    PC_Write = 1'b0;
    step(); step(); expect_state("stall", 64'd4, 1'b0, 32'd1);
    chk("stall_instr", {32'h0, Instruction}, 64'h00A0_0113);
    PC_Write = 1'b1;
    step(); expect_state("resume", 64'd8, 1'b0, 32'd2);

    // Redirect during stall.
    PC_Write = 1'b0; branch_taken = 1'b1; branch_target = 64'd0; #1;
    chk("redir_flush", {63'h0, IF_flush}, 64'h1);
    step(); branch_taken = 1'b0;
    expect_state("redir", 64'd0, 1'b0, 32'd2);

    // Same-cycle write to the fetched word is only visible after the edge.
    imem_we = 1'b1; imem_waddr = 4'd0; imem_wdata = 32'h1111_1111; #1;
    chk("wr_before", {32'h0, Instruction}, 64'h0050_0093);
    step(); imem_we = 1'b0;
    chk("wr_after", {32'h0, Instruction}, 64'h1111_1111);
    imem_we = 1'b1; imem_wdata = 32'h0050_0093;
    step(); imem_we = 1'b0;

    // Run to halt, then exit HALT with a redirect.
    PC_Write = 1'b1;
    step(); step(); step(); step();
    expect_state("halt2", 64'd12, 1'b1, 32'd5);
    branch_taken = 1'b1; branch_target = 64'd4;
    step(); expect_state("exit", 64'd4, 1'b0, 32'd5);

    // Misaligned and out-of-range target halts after one attempt.
    branch_target = 64'h42;
    step(); branch_taken = 1'b0;
    expect_state("mis", 64'h42, 1'b0, 32'd5);
    chk("mis_instr", {32'h0, Instruction}, {32'h0, NOP});
    step(); expect_state("mis_halt", 64'h42, 1'b1, 32'd5);

    // Redirect coinciding with a terminal fetch keeps RUN.
    branch_taken = 1'b1; branch_target = 64'h100;
    step(); expect_state("far", 64'h100, 1'b0, 32'd5);
    branch_target = 64'd8;
    step(); branch_taken = 1'b0;
    expect_state("redir_wins", 64'd8, 1'b0, 32'd5);
    step(); expect_state("last12", 64'd12, 1'b0, 32'd6);
    step(); expect_state("last_halt", 64'd12, 1'b1, 32'd6);

    @(negedge clk); chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
